pwm_event_scheduler: RTL and testbench
======================================

// Module: pwm_event_scheduler
// PURPOSE
//  Per-carrier event decimation plus interrupt scheduling for the 8-carrier PWM block.
//  Each carrier raises a one-clk event pulse; the block passes 1 of every (count+1) events,
//  turns passed events into pending flags, and shares one PS interrupt line between them
//  (round-robin, irq/ack handshake). Config updates to counts are shadowed to wrap points.
// PARAMETERS
//  N_CARR  8  number of carriers / requesters
//  EVT_W   4  event counter width; count range 0..2^EVT_W-1
// PORTS
//  clk        in   1           system clock
//  reset      in   1           asynchronous, active-low reset
//  carr_evt   in   N_CARR      per-carrier event pulse, 1 clk wide, clk-synchronous
//  carr_en    in   N_CARR      per-carrier carrier on/off
//  pwm_onoff  in   1           global PWM enable; 0 = events ignored
//  int_onoff  in   1           global interrupt enable; 0 = passed events not latched
//  mask_en    in   N_CARR      1 = decimate by count; 0 = NO_MASK, every event passes
//  cfg_count  in   N_CARR*EVT_W  new per-carrier counts (carrier i at [i*EVT_W +: EVT_W])
//  cfg_load   in   1           1-clk pulse: capture cfg_count into staging registers
//  irq        out  1           interrupt request to PS
//  irq_src    out  clog2(N_CARR) carrier being served; stable while irq=1
//  irq_ack    in   1           PS acknowledge; sampled only while irq=1
//  pend       out  N_CARR      pending flags
//  ovr        out  N_CARR      sticky overrun flags
//  ovr_clr    in   N_CARR      per-bit clear of ovr
// BEHAVIOUR
//  - Reset: cnt, active count, staging, load flags, pend, ovr = 0; irq=0, irq_src=0, rr ptr=0, FSM IDLE.
//  - Qualified event q_i = carr_evt[i] & carr_en[i] & pwm_onoff.
//  - mask_en[i]=1: on q_i, if cnt_i==act_i -> cnt_i<=0, pass; else cnt_i<=cnt_i+1, no pass.
//    act_i=0 passes every event. mask_en[i]=0: pass on every q_i, cnt_i held 0.
//  - pwm_onoff=0 or carr_en[i]=0: cnt_i held (not cleared); pend/ovr retained.
//  - cfg_load: stage_i<=cfg_count slice, ldp_i<=1 for all i. Applied (act_i<=stage_i,
//    ldp_i<=0) in the same clk as a pass-with-wrap of carrier i, or the first clk carr_en[i]=0
//    or mask_en[i]=0. A second cfg_load before apply overwrites stage_i.
//  - Pass with int_onoff=1: pend_i<=1 next clk; if pend_i already 1 and not being cleared
//    this clk -> ovr_i<=1. ovr_clr[i] and ovr set same clk: set wins.
//  - FSM IDLE: if |pend -> grant = first set bit at or after ptr (wrapping), irq_src<=grant,
//    irq<=1, -> REQ. Latency: carr_evt at clk t -> pend at t+1 -> irq at t+2.
//  - REQ: irq, irq_src held; on irq_ack: pend[irq_src]<=0, irq<=0, ptr<=irq_src+1 (mod N),
//    -> GAP. int_onoff falling during REQ does not drop irq.
//  - GAP: one clk with irq=0 -> IDLE (guarantees ack deassert visibility).
//  - Pass on carrier irq_src in the ack clk: set wins, pend stays 1, no ovr.
//  - irq_ack outside REQ ignored. Reset mid-handshake: all state to reset values.
// STRUCTURE
//  - pwm_pkg: N_CARR, EVT_W defaults, sched_state_t enum {IDLE, REQ, GAP}, NO_MASK constant.
//  - Sub-module evt_div_ch: one carrier's cnt/act/stage/ldp/pend/ovr; generate N_CARR copies.
//  - Top: rr grant logic (masked priority encode from ptr) + 3-state FSM.
// TESTING
//  1 mask_en[0]=1, count 3, 8 events on ch0 -> pend[0] rises after events 4 and 8 only.
//  2 count 3, cfg_load count 1 after 2 events -> next pass still at event 4, then every 2nd.
//  3 pend set on ch2,ch5,ch6, ptr=0, ack each 2 clk after irq -> irq_src 2,5,6; GAP 1 clk each.
//  4 ch1 pass while pend[1]=1 -> ovr[1]=1; ovr_clr[1] same clk as second overrun -> ovr stays 1.
//  5 ch3 event in ack clk of irq_src=3 -> pend[3] stays 1, ovr[3]=0, irq reasserts after GAP.
//  6 reset low during REQ with pend=8'hFF -> irq=0, pend=0, ptr=0 asynchronously.

Source files
------------

// File: rtl/pwm_event_scheduler_pkg.sv
// ============================================================================
// Module : pwm_event_scheduler_pkg
// Brief  : Shared defaults, scheduler state encoding and helpers for the
//          PWM event scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_event_scheduler_pkg;

    localparam int   N_CARR_DEF = 8;
    localparam int   EVT_W_DEF  = 4;
    // mask_en value that disables decimation (every qualified event passes)
    localparam logic NO_MASK    = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_event_scheduler_if.sv
// ============================================================================
// Module : pwm_event_scheduler_if
// Brief  : Interrupt request/acknowledge handshake between scheduler and PS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import pwm_event_scheduler_pkg::*;

interface pwm_event_scheduler_if #(
    parameter int N_CARR = N_CARR_DEF
) ();
    localparam int SRC_W = (N_CARR > 1) ? $clog2(N_CARR) : 1;

    logic             irq;
    logic [SRC_W-1:0] irq_src;
    logic             irq_ack;

    modport master (output irq, output irq_src, input  irq_ack);
    modport slave  (input  irq, input  irq_src, output irq_ack);
endinterface

`default_nettype wire

// File: rtl/pwm_event_scheduler_evt_div_ch.sv
// ============================================================================
// Module : pwm_event_scheduler_evt_div_ch
// Brief  : One carrier: event decimator with shadowed count, pending and
//          sticky overrun flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import pwm_event_scheduler_pkg::*;

module pwm_event_scheduler_evt_div_ch #(
    parameter int EVT_W = EVT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             evt,
    input  wire logic             carr_en,
    input  wire logic             pwm_onoff,
    input  wire logic             int_onoff,
    input  wire logic             mask_en,
    input  wire logic [EVT_W-1:0] cfg_count,
    input  wire logic             cfg_load,
    input  wire logic             ack_clr,
    input  wire logic             ovr_clr,
    output logic                  pend,
    output logic                  ovr
);

    logic [EVT_W-1:0] cnt;
    logic [EVT_W-1:0] act;
    logic [EVT_W-1:0] stage;
    logic             ldp;

    logic qual;
    logic at_wrap;
    logic pass;
    logic apply;
    logic pend_set;

    always_comb begin
        qual     = evt & carr_en & pwm_onoff;
        at_wrap  = qual & (mask_en != NO_MASK) & (cnt == act);
        pass     = qual & ((mask_en == NO_MASK) | (cnt == act));
        // A staged count only takes effect where it cannot cut a running period short
        apply    = ldp & (at_wrap | ~carr_en | (mask_en == NO_MASK));
        pend_set = pass & int_onoff;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            act   <= '0;
            stage <= '0;
            ldp   <= 1'b0;
            pend  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            if (mask_en == NO_MASK)
                cnt <= '0;
            else if (qual)
                cnt <= (cnt == act) ? '0 : cnt + 1'b1;

            if (apply)
                act <= stage;

            if (cfg_load) begin
                stage <= cfg_count;
                ldp   <= 1'b1;
            end else if (apply) begin
                ldp   <= 1'b0;
            end

            // A new pass beats an acknowledge landing in the same clock
            pend <= pend_set | (pend & ~ack_clr);
            ovr  <= (pend_set & pend & ~ack_clr) | (ovr & ~ovr_clr);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_event_scheduler.sv
// ============================================================================
// Module : pwm_event_scheduler
// Brief  : Per-carrier event decimation with round-robin sharing of one
//          interrupt line (irq/ack handshake).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import pwm_event_scheduler_pkg::*;

module pwm_event_scheduler #(
    parameter int N_CARR = N_CARR_DEF,
    parameter int EVT_W  = EVT_W_DEF
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic [N_CARR-1:0]       carr_evt,
    input  wire logic [N_CARR-1:0]       carr_en,
    input  wire logic                    pwm_onoff,
    input  wire logic                    int_onoff,
    input  wire logic [N_CARR-1:0]       mask_en,
    input  wire logic [N_CARR*EVT_W-1:0] cfg_count,
    input  wire logic                    cfg_load,
    output logic      [N_CARR-1:0]       pend,
    output logic      [N_CARR-1:0]       ovr,
    input  wire logic [N_CARR-1:0]       ovr_clr,
    pwm_event_scheduler_if.master        irq_bus
);

    localparam int SRC_W = (N_CARR > 1) ? $clog2(N_CARR) : 1;

    sched_state_t     state, state_nxt;
    logic             req, req_nxt;
    logic [SRC_W-1:0] src, src_nxt;
    logic [SRC_W-1:0] ptr, ptr_nxt;
    logic             ack_hit;
    logic [N_CARR-1:0] ack_clr;
    logic             grant_valid;
    logic [SRC_W-1:0] grant;

    for (genvar i = 0; i < N_CARR; i++) begin : g_ch
        pwm_event_scheduler_evt_div_ch #(
            .EVT_W (EVT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .evt       (carr_evt[i]),
            .carr_en   (carr_en[i]),
            .pwm_onoff (pwm_onoff),
            .int_onoff (int_onoff),
            .mask_en   (mask_en[i]),
            .cfg_count (cfg_count[i*EVT_W +: EVT_W]),
            .cfg_load  (cfg_load),
            .ack_clr   (ack_clr[i]),
            .ovr_clr   (ovr_clr[i]),
            .pend      (pend[i]),
            .ovr       (ovr[i])
        );
    end

    // Scan from the highest offset down so the nearest set bit at/after ptr wins
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = N_CARR - 1; k >= 0; k--) begin
            if (pend[(int'(ptr) + k) % N_CARR]) begin
                grant_valid = 1'b1;
                grant       = SRC_W'((int'(ptr) + k) % N_CARR);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req   <= 1'b0;
            src   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            req   <= req_nxt;
            src   <= src_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        src_nxt   = src;
        ptr_nxt   = ptr;
        ack_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_nxt   = 1'b1;
                    src_nxt   = grant;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (irq_bus.irq_ack) begin
                    ack_hit   = 1'b1;
                    req_nxt   = 1'b0;
                    ptr_nxt   = SRC_W'(wrap_inc(32'(src), N_CARR));
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_clr = '0;
        if (ack_hit)
            ack_clr[src] = 1'b1;
    end

    assign irq_bus.irq     = req;
    assign irq_bus.irq_src = src;

endmodule

`default_nettype wire

// File: tb/tb_pwm_event_scheduler.sv
// ============================================================================
// Module : tb_pwm_event_scheduler
// Brief  : Directed self-checking bench for pwm_event_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_event_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  carr_evt = '0;
    logic [7:0]  carr_en = '0;
    logic        pwm_onoff = 1'b0;
    logic        int_onoff = 1'b0;
    logic [7:0]  mask_en = '0;
    logic [31:0] cfg_count = '0;
    logic        cfg_load = 1'b0;
    logic [7:0]  pend;
    logic [7:0]  ovr;
    logic [7:0]  ovr_clr = '0;

    int total = 0;
    int bad   = 0;

    pwm_event_scheduler_if #(.N_CARR(8)) irq_bus ();

    pwm_event_scheduler #(.N_CARR(8), .EVT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .carr_evt  (carr_evt),
        .carr_en   (carr_en),
        .pwm_onoff (pwm_onoff),
        .int_onoff (int_onoff),
        .mask_en   (mask_en),
        .cfg_count (cfg_count),
        .cfg_load  (cfg_load),
        .pend      (pend),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr),
        .irq_bus   (irq_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] m);
        carr_evt = m;
        tick();
        carr_evt = '0;
    endtask

    // Entered with irq already high; acks two clocks after irq, checks the gap
    task automatic serve(input int s);
        chk($sformatf("irq_up_%0d", s), 32'(irq_bus.irq), 32'd1);
        chk($sformatf("src_%0d", s), 32'(irq_bus.irq_src), 32'(s));
        tick();
        chk($sformatf("src_held_%0d", s), 32'(irq_bus.irq_src), 32'(s));
        irq_bus.irq_ack = 1'b1;
        tick();
        irq_bus.irq_ack = 1'b0;
        chk($sformatf("irq_ackdrop_%0d", s), 32'(irq_bus.irq), 32'd0);
        chk($sformatf("pend_clr_%0d", s), 32'(pend[s]), 32'd0);
        tick();
        chk($sformatf("irq_gap_%0d", s), 32'(irq_bus.irq), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        irq_bus.irq_ack = 1'b0;
        tick();
        tick();
        chk("rst_irq", 32'(irq_bus.irq), 32'd0);
        chk("rst_src", 32'(irq_bus.irq_src), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        reset = 1'b1;
        pwm_onoff = 1'b1;
        int_onoff = 1'b1;
        carr_en   = 8'hFF;

        // Decimate ch0 by 4: count 3 applied while unmasked, then mask on
        cfg_count = 32'h0000_0003;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
        tick();
        mask_en   = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            pulse(8'h01);
            chk($sformatf("t1_pend_e%0d", e), 32'(pend[0]), (e % 4 == 0) ? 32'd1 : 32'd0);
            if (e % 4 == 0) begin
                tick();
                serve(0);
            end
        end

        // Count change to 1 after two events: takes effect at the next wrap
        for (int e = 1; e <= 8; e++) begin
            if (e == 3) begin
                cfg_count = 32'h0000_0001;
                cfg_load  = 1'b1;
                tick();
                cfg_load  = 1'b0;
            end
            pulse(8'h01);
            chk($sformatf("t2_pend_e%0d", e), 32'(pend[0]),
                (e == 4 || e == 6 || e == 8) ? 32'd1 : 32'd0);
            if (e == 4 || e == 6 || e == 8) begin
                tick();
                serve(0);
            end
        end

        // Round robin from ptr=0 over ch2, ch5, ch6
        do_reset();
        mask_en = 8'h00;
        pulse(8'h64);
        chk("t3_pend", 32'(pend), 32'h64);
        tick();
        serve(2);
        serve(5);
        serve(6);
        chk("t3_pend_done", 32'(pend), 32'h00);
        chk("t3_irq_done", 32'(irq_bus.irq), 32'd0);

        // Overrun on ch1, set beats clear, then clear alone works
        pulse(8'h02);
        chk("t4_pend", 32'(pend), 32'h02);
        chk("t4_ovr0", 32'(ovr), 32'h00);
        pulse(8'h02);
        chk("t4_ovr1", 32'(ovr), 32'h02);
        ovr_clr = 8'h02;
        pulse(8'h02);
        ovr_clr = 8'h00;
        chk("t4_ovr_setwins", 32'(ovr), 32'h02);
        ovr_clr = 8'h02;
        tick();
        ovr_clr = 8'h00;
        chk("t4_ovr_clr", 32'(ovr), 32'h00);
        serve(1);

        // Interrupts disabled: passed event is not latched
        int_onoff = 1'b0;
        pulse(8'h10);
        chk("int_off_pend", 32'(pend), 32'h00);
        tick();
        chk("int_off_irq", 32'(irq_bus.irq), 32'd0);
        int_onoff = 1'b1;

        // ch3 event lands in the ack clock of irq_src=3
        pulse(8'h08);
        tick();
        chk("t5_irq", 32'(irq_bus.irq), 32'd1);
        chk("t5_src", 32'(irq_bus.irq_src), 32'd3);
        irq_bus.irq_ack = 1'b1;
        carr_evt = 8'h08;
        tick();
        irq_bus.irq_ack = 1'b0;
        carr_evt = 8'h00;
        chk("t5_pend_kept", 32'(pend), 32'h08);
        chk("t5_no_ovr", 32'(ovr), 32'h00);
        chk("t5_irq_drop", 32'(irq_bus.irq), 32'd0);
        tick();
        chk("t5_gap", 32'(irq_bus.irq), 32'd0);
        tick();
        serve(3);
        chk("t5_pend_done", 32'(pend), 32'h00);

        // Asynchronous reset in the middle of a request
        pulse(8'hFF);
        chk("t6_pend_ff", 32'(pend), 32'hFF);
        tick();
        chk("t6_irq", 32'(irq_bus.irq), 32'd1);
        chk("t6_src", 32'(irq_bus.irq_src), 32'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_irq", 32'(irq_bus.irq), 32'd0);
        chk("t6_rst_pend", 32'(pend), 32'h00);
        chk("t6_rst_src", 32'(irq_bus.irq_src), 32'd0);
        tick();
        reset = 1'b1;
        pulse(8'hFF);
        tick();
        chk("t6_ptr0", 32'(irq_bus.irq_src), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
